// File: rtl/pc_next_unit.sv
// ============================================================================
// pc_next_unit : fetch-stage PC register with prioritised redirects and a
//                one-entry pending redirect buffer for stalls.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pc_next_unit #(
   parameter int               WIDTH        = 32,
   parameter int               NUM_REDIRECT = 2,
   parameter logic [WIDTH-1:0] RESET_PC     = '0,
   parameter logic [WIDTH-1:0] INC          = WIDTH'(4)
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          pcWrite,
   input  logic [NUM_REDIRECT-1:0]       redirectValid,
   input  logic [NUM_REDIRECT*WIDTH-1:0] redirectTarget,
   output logic [WIDTH-1:0]              pc,
   output logic [WIDTH-1:0]              pcPlus,
   output logic                          pendingValid,
   output logic                          flush
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_target_q, pend_target_d;
   logic             pend_valid_q, pend_valid_d;
   logic             flush_q, flush_d;

   logic [WIDTH-1:0] w_sel_target;
   logic             w_any_redirect;

   // Scan from the highest index down so the lowest-index request wins.
   always_comb begin
      w_sel_target = '0;
      for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
         if (redirectValid[i]) begin
            w_sel_target = redirectTarget[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_any_redirect = |redirectValid;

   always_comb begin
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      pend_valid_d  = pend_valid_q;
      flush_d       = 1'b0;
      if (pcWrite) begin
         if (pend_valid_q) begin
            // The buffered redirect is older than anything arriving now.
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            flush_d      = 1'b1;
         end else if (w_any_redirect) begin
            pc_d    = w_sel_target;
            flush_d = 1'b1;
         end else begin
            pc_d = pc_q + INC;
         end
      end else if (!pend_valid_q && w_any_redirect) begin
         pend_target_d = w_sel_target;
         pend_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         pc_q          <= RESET_PC;
         pend_target_q <= '0;
         pend_valid_q  <= 1'b0;
         flush_q       <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         pend_valid_q  <= pend_valid_d;
         flush_q       <= flush_d;
      end
   end

   assign pc           = pc_q;
   assign pcPlus       = pc_q + INC;
   assign pendingValid = pend_valid_q;
   assign flush        = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// tb_pc_next_unit : directed scenarios plus random stimulus against a
//                   behavioural PC model.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_next_unit;

   logic        clk = 1'b0;
   logic        rstN;
   logic        pcWrite;
   logic [1:0]  redirectValid;
   logic [63:0] redirectTarget;
   logic [31:0] pc;
   logic [31:0] pcPlus;
   logic        pendingValid;
   logic        flush;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: the pending redirect is held as a queue of at most one target.
   logic [31:0] m_pc;
   logic [31:0] m_pend[$];
   logic        m_flush;

   always #5 clk = ~clk;

   pc_next_unit #(
      .WIDTH       (32),
      .NUM_REDIRECT(2),
      .RESET_PC    (32'h0),
      .INC         (32'h4)
   ) dut (
      .clk           (clk),
      .rstN          (rstN),
      .pcWrite       (pcWrite),
      .redirectValid (redirectValid),
      .redirectTarget(redirectTarget),
      .pc            (pc),
      .pcPlus        (pcPlus),
      .pendingValid  (pendingValid),
      .flush         (flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic rst_n, input logic pw, input logic [1:0] rv,
                       input logic [31:0] t0, input logic [31:0] t1);
      logic [31:0] sel;
      rstN           = rst_n;
      pcWrite        = pw;
      redirectValid  = rv;
      redirectTarget = {t1, t0};
      sel            = rv[0] ? t0 : t1;
      @(posedge clk);
      if (!rst_n) begin
         m_pc    = 32'h0;
         m_pend.delete();
         m_flush = 1'b0;
      end else if (pw) begin
         if (m_pend.size() != 0) begin
            m_pc    = m_pend.pop_front();
            m_flush = 1'b1;
         end else if (rv != 2'b00) begin
            m_pc    = sel;
            m_flush = 1'b1;
         end else begin
            m_pc    = m_pc + 32'd4;
            m_flush = 1'b0;
         end
      end else begin
         m_flush = 1'b0;
         if (m_pend.size() == 0 && rv != 2'b00) m_pend.push_back(sel);
      end
      #1;
      chk("pc", pc, m_pc);
      chk("pcPlus", pcPlus, m_pc + 32'd4);
      chk("pendingValid", {31'd0, pendingValid}, {31'd0, m_pend.size() != 0});
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
   endtask

   initial begin
      m_pc    = 32'h0;
      m_flush = 1'b0;

      // Reset then sequential fetch.
      step(0, 1, 2'b00, 0, 0);
      step(0, 1, 2'b00, 0, 0);
      chk("reset_pc", pc, 32'h0);
      chk("reset_pcPlus", pcPlus, 32'h4);
      for (int i = 0; i < 3; i++) step(1, 1, 2'b00, 0, 0);
      chk("seq_pc", pc, 32'hC);

      // Priority: both channels request, channel 0 wins.
      step(1, 1, 2'b00, 0, 0);
      chk("pre_prio_pc", pc, 32'h10);
      step(1, 1, 2'b11, 32'h100, 32'h200);
      chk("prio_pc", pc, 32'h100);
      chk("prio_flush", {31'd0, flush}, 32'd1);
      step(1, 1, 2'b00, 0, 0);
      chk("prio_after", pc, 32'h104);

      // Stall capture, first redirect wins.
      step(1, 0, 2'b01, 32'h40, 0);
      chk("cap_pv", {31'd0, pendingValid}, 32'd1);
      step(1, 0, 2'b10, 0, 32'h80);
      step(1, 1, 2'b10, 0, 32'h80);
      chk("release_pc", pc, 32'h40);
      chk("release_flush", {31'd0, flush}, 32'd1);
      step(1, 1, 2'b00, 0, 0);
      chk("release_next", pc, 32'h44);

      // Stall hold.
      for (int i = 0; i < 5; i++) step(1, 0, 2'b00, 0, 0);
      chk("hold_pc", pc, 32'h44);

      // Wrap-around.
      step(1, 1, 2'b01, 32'hFFFF_FFFC, 0);
      step(1, 1, 2'b00, 0, 0);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pcPlus", pcPlus, 32'h4);

      // Reset while a redirect is pending.
      step(1, 0, 2'b01, 32'h40, 0);
      step(0, 1, 2'b00, 0, 0);
      chk("rst_pend_pv", {31'd0, pendingValid}, 32'd0);
      step(1, 1, 2'b00, 0, 0);
      chk("rst_pend_pc", pc, 32'h4);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] t0, t1;
         t0 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         t1 = $urandom;
         step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00, t0, t1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter generator for the MIPS pipeline fetch stage. It replaces the combinational PC select with a parametrised unit. The unit holds the PC register and chooses the next PC from a sequential increment or N prioritised redirect channels (branch, jump, and later exception). A redirect that arrives while fetch is stalled is buffered in a one-entry pending register and applied when the stall releases. A one-cycle flush pulse is emitted whenever the PC is loaded from a redirect.

## Interface
- WIDTH, 32, PC and target width in bits.
- NUM_REDIRECT, 2, number of redirect channels (≥1). Channel 0 has highest priority; channel 0 is branch, channel 1 is jump.
- RESET_PC, 0, PC value loaded on reset.
- INC, 4, sequential increment added to the PC.
- clk  input  1  clock; all state updates on rising edge.
- rstN  input  1  reset; synchronous, active-low.
- pcWrite  input  1  1 = PC may advance; 0 = stall (hold PC).
- redirectValid  input  NUM_REDIRECT  per-channel redirect request.
- redirectTarget  input  NUM_REDIRECT*WIDTH  channel i target in bits [i*WIDTH +: WIDTH].
- pc  output  WIDTH  current PC (register).
- pcPlus  output  WIDTH  pc + INC, combinational, modulo 2^WIDTH.
- pendingValid  output  1  buffered redirect waiting for stall release (register).
- flush  output  1  high for exactly one cycle after the PC is loaded from a redirect (register).

## Operation
- Selected redirect is the lowest-index channel with redirectValid set. anyRedirect is the OR of redirectValid.
- State consists of pc, pendingValid, pendingTarget, and flush.
- When rstN is 0 at an edge, the unit loads pc=RESET_PC, pendingValid=0, and flush=0. Reset overrides all other inputs, including a mid-stall pending redirect.
- When pcWrite=1, the first matching case below applies:
  - If pendingValid=1, load pc from pendingTarget, clear pendingValid, and set flush=1. The pending redirect is older and wins, so any same-cycle redirectValid is dropped.
  - Else if anyRedirect=1, load pc from the selected target and set flush=1.
  - Otherwise, load pc from pc+INC and set flush=0.
- When pcWrite=0, pc holds and flush=0.
  - If pendingValid=0 and anyRedirect=1, capture the selected target into pendingTarget and set pendingValid=1.
  - If pendingValid=1, redirects are ignored; the first captured redirect wins.
- Arithmetic: pc+INC is truncated to WIDTH bits, so 2^WIDTH−INC wraps to 0. Targets are used unmodified, with no alignment check.
- redirectTarget bits of channels whose redirectValid is 0 are don't-care.

## Timing
- A redirect applied with pcWrite=1 becomes visible on pc one cycle later, and flush is high in that same cycle.
- A redirect captured during a stall appears on pc one cycle after the first cycle with pcWrite=1.
- pendingValid rises one cycle after capture and falls in the cycle pc takes pendingTarget.
- flush is never high for two consecutive cycles unless a redirect is applied on two consecutive edges.
- pcPlus follows pc combinationally with zero latency.
- There are no combinational paths from inputs to pc, pendingValid, or flush.
- Reset values: pc=RESET_PC, pendingValid=0, flush=0, and pcPlus=RESET_PC+INC.

## Test plan
Defaults for all scenarios: WIDTH=32, NUM_REDIRECT=2, RESET_PC=0, INC=4.
- Reset then sequential fetch: hold rstN=0 for 2 cycles, then rstN=1 with pcWrite=1 and no redirects for 3 cycles → pc = 0x0, 0x4, 0x8, 0xC; flush=0 throughout; pcPlus always pc+4.
- Priority: with pc=0x10, pcWrite=1, redirectValid=2'b11, ch0 target=0x100, ch1 target=0x200 → next pc=0x100, flush=1 for one cycle, then pc=0x104 with flush=0.
- Stall capture and first-wins:
  - pcWrite=0, redirectValid=2'b01, target 0x40 → pc holds, pendingValid=1 next cycle.
  - Next cycle, pcWrite=0, redirectValid=2'b10, target 0x80 → ignored.
  - Next cycle, pcWrite=1, redirectValid=2'b10, target 0x80 → pc=0x40, pendingValid=0, flush=1.
  - Following cycle → pc=0x44.
- Stall hold: pcWrite=0 with no redirects for 5 cycles → pc unchanged, flush=0, pendingValid=0.
- Wrap-around: redirect to 0xFFFFFFFC, then pcWrite=1 with no redirect → pc=0x00000000, pcPlus=0x4.
- Reset mid-pending: capture a redirect to 0x40 during a stall, then rstN=0 for one edge → pc=0x0, pendingValid=0, flush=0. After rstN=1 with pcWrite=1 → pc=0x4, with no stale redirect applied.
